// File: rtl/sd_sector_arbiter_pkg.sv
// Shared types for the SD sector arbiter: FSM encoding and bus widths.
package sd_sector_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT = 2**24;
    localparam int LBA_W       = 32;
    localparam int BYTE_W      = 8;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending requester at/after ptr.
module sd_sector_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Round-robin owner of the SD block port: one sector transaction at a time,
// with ack synchroniser, ISSUE timeout and per-requester done/err pulses.
module sd_sector_arbiter
    import sd_sector_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_rd,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [LBA_W*NREQ-1:0]   req_lba,
    input  logic [BYTE_W*NREQ-1:0]  req_buff_din,
    output logic [NREQ-1:0]         req_buff_wr,
    output logic [NREQ-1:0]         req_ack,
    output logic [NREQ-1:0]         req_done,
    output logic [NREQ-1:0]         req_err,
    output logic [NREQ-1:0]         grant,
    output logic [LBA_W-1:0]        sd_lba,
    output logic                    sd_rd,
    output logic                    sd_wr,
    input  logic                    sd_ack,
    input  logic                    sd_buff_wr,
    output logic [BYTE_W-1:0]       sd_buff_din
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   grant_q, pend, pick;
    logic [PW-1:0]     ptr_q, ptr_next;
    logic [CW-1:0]     cnt_q;
    logic [LBA_W-1:0]  lba_q, lba_pick;
    logic              op_rd_q, err_q, pick_rd;
    logic              ack_m, ack_s, ack_d;
    logic              ack_rise, ack_fall, tmo;

    assign pend     = req_rd | req_wr;
    assign ack_rise = ack_s & ~ack_d;
    assign ack_fall = ~ack_s & ack_d;
    assign tmo      = (cnt_q == CW'(TIMEOUT - 1));

    // Left out of reset on purpose: a stale high ack must survive reset
    // and keep IDLE from granting until the I/O module releases it.
    always_ff @(posedge clk_sys) begin
        ack_m <= sd_ack;
        ack_s <= ack_m;
        ack_d <= ack_s;
    end

    sd_sector_arbiter_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (pend),
        .ptr  (ptr_q),
        .gnt  (pick)
    );

    always_comb begin
        lba_pick = '0;
        pick_rd  = 1'b0;
        ptr_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                lba_pick = req_lba[LBA_W*i +: LBA_W];
                pick_rd  = req_rd[i];
            end
            if (grant_q[i]) begin
                ptr_next = PW'(rr_next(i, NREQ));
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!ack_s && |pend) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ack_rise) begin
                    state_d = ST_XFER;
                end else if (tmo) begin
                    state_d = ST_DONE;
                end
            end
            ST_XFER: begin
                if (ack_fall) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            grant_q <= '0;
            lba_q   <= '0;
            op_rd_q <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= (state_q == ST_ISSUE) ? cnt_q + 1'b1 : '0;
            if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
                grant_q <= pick;
                lba_q   <= lba_pick;
                op_rd_q <= pick_rd;
                err_q   <= 1'b0;
            end
            if (state_q == ST_ISSUE && !ack_rise && tmo) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_DONE) begin
                grant_q <= '0;
                ptr_q   <= ptr_next;
            end
        end
    end

    always_comb begin
        sd_rd       = 1'b0;
        sd_wr       = 1'b0;
        req_ack     = '0;
        req_buff_wr = '0;
        req_done    = '0;
        req_err     = '0;
        sd_buff_din = '0;
        unique case (state_q)
            ST_ISSUE: begin
                sd_rd = op_rd_q;
                sd_wr = ~op_rd_q;
            end
            ST_XFER: begin
                req_ack     = grant_q;
                req_buff_wr = sd_buff_wr ? grant_q : '0;
            end
            ST_DONE: begin
                req_done = grant_q;
                req_err  = err_q ? grant_q : '0;
            end
            default: begin
            end
        endcase
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                sd_buff_din = req_buff_din[BYTE_W*i +: BYTE_W];
            end
        end
    end

    assign grant  = grant_q;
    assign sd_lba = lba_q;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Scoreboard bench for sd_sector_arbiter with a behavioural SD card model.
module tb_sd_sector_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 100;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_rd = '0;
    logic [NREQ-1:0]   req_wr = '0;
    logic [32*NREQ-1:0] req_lba = '0;
    logic [8*NREQ-1:0] req_buff_din = '0;
    logic [NREQ-1:0]   req_buff_wr, req_ack, req_done, req_err, grant;
    logic [31:0]       sd_lba;
    logic              sd_rd, sd_wr;
    logic              sd_ack = 1'b0;
    logic              sd_buff_wr = 1'b0;
    logic [7:0]        sd_buff_din;

    typedef struct {
        int          idx;
        logic [31:0] lba;
        bit          rd;
        bit          err;
        int          strobes;
        int          tcyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   card_mute = 1'b0;

    always #5 clk_sys = ~clk_sys;

    sd_sector_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_buff_din (req_buff_din),
        .req_buff_wr  (req_buff_wr),
        .req_ack      (req_ack),
        .req_done     (req_done),
        .req_err      (req_err),
        .grant        (grant),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int who);
        int n;
        n = 0;
        while (req_done[who] !== 1'b1 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        chk($sformatf("done_wait%0d", who), 32'(n < 3000), 32'd1);
        req_rd[who] = 1'b0;
        req_wr[who] = 1'b0;
        @(negedge clk_sys);
    endtask

    // Card: ack a few cycles after the command, stream strobes, release.
    initial begin
        int ns;
        forever begin
            @(negedge clk_sys);
            if ((sd_rd || sd_wr) && !card_mute && !reset) begin
                ns = sd_rd ? 512 : 16;
                repeat (3) @(negedge clk_sys);
                sd_ack = 1'b1;
                repeat (6) @(negedge clk_sys);
                sd_buff_wr = 1'b1;
                repeat (ns) @(negedge clk_sys);
                sd_buff_wr = 1'b0;
                repeat (4) @(negedge clk_sys);
                sd_ack = 1'b0;
            end
        end
    end

    // Monitor: compare each issue against the queue head, pop on done.
    initial begin
        bit   prev_iss, iss, din_done;
        int   strobes, stray, icyc, acyc;
        exp_t e;
        prev_iss = 1'b0;
        din_done = 1'b0;
        strobes = 0; stray = 0; icyc = 0; acyc = 0;
        e = '{0, 32'h0, 1'b0, 1'b0, 0, -1};
        forever begin
            @(negedge clk_sys);
            #2;
            if (reset) begin
                prev_iss = 1'b0;
            end else begin
                iss = sd_rd | sd_wr;
                if (iss && !prev_iss) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_issue", 32'd1, 32'd0);
                    end else begin
                        e = exp_q[0];
                        chk("grant", 32'(grant), 32'(1 << e.idx));
                        chk("sd_lba", sd_lba, e.lba);
                        chk("sd_rd", 32'(sd_rd), 32'(e.rd));
                        chk("sd_wr", 32'(sd_wr), 32'(!e.rd));
                    end
                    strobes = 0; stray = 0; icyc = 0; acyc = 0;
                    din_done = 1'b0;
                end
                if (iss) icyc++;
                if (req_ack != '0) acyc++;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_buff_wr[i]) begin
                        if (i == e.idx) strobes++;
                        else stray++;
                    end
                end
                if (req_ack != '0 && !din_done) begin
                    din_done = 1'b1;
                    chk("req_ack", 32'(req_ack), 32'(1 << e.idx));
                    chk("sd_buff_din", 32'(sd_buff_din),
                        32'((req_buff_din >> (8 * e.idx)) & 16'h00ff));
                end
                if (req_done != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("req_done", 32'(req_done), 32'(1 << e.idx));
                        chk("req_err", 32'(req_err),
                            e.err ? 32'(1 << e.idx) : 32'd0);
                        chk("strobes", 32'(strobes), 32'(e.strobes));
                        chk("stray_strobes", 32'(stray), 32'd0);
                        chk("acked", 32'(acyc > 0), 32'(!e.err));
                        if (e.tcyc > 0) begin
                            chk("issue_cycles", 32'(icyc), 32'(e.tcyc));
                        end
                    end
                end
                prev_iss = iss;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  bad;
        repeat (4) @(negedge clk_sys);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sd_rd", 32'(sd_rd), 32'd0);
        chk("rst_sd_wr", 32'(sd_wr), 32'd0);
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_flags", 32'({req_ack, req_done, req_err}), 32'd0);
        reset = 1'b0;
        @(negedge clk_sys);

        // Single read on requester 0.
        exp_q.push_back('{0, 32'h1234, 1'b1, 1'b0, 512, -1});
        req_lba[31:0] = 32'h1234;
        req_rd[0] = 1'b1;
        wait_done(0);

        // Simultaneous read(0)/write(1) from pointer 0, then 0 re-requests.
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        exp_q.push_back('{0, 32'h1000, 1'b1, 1'b0, 512, -1});
        exp_q.push_back('{1, 32'h2000, 1'b0, 1'b0, 16, -1});
        req_lba[31:0]  = 32'h1000;
        req_lba[63:32] = 32'h2000;
        req_buff_din[15:8] = 8'hA5;
        req_buff_din[7:0]  = 8'h11;
        req_rd[0] = 1'b1;
        req_wr[1] = 1'b1;
        wait_done(0);
        exp_q.push_back('{0, 32'h3000, 1'b1, 1'b0, 512, -1});
        req_lba[31:0] = 32'h3000;
        req_rd[0] = 1'b1;
        n = 0;
        while (grant !== 2'b10 && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        chk("fair_grant", 32'(grant), 32'h2);
        req_lba[63:32] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk_sys);
        chk("lba_hold", sd_lba, 32'h2000);
        wait_done(1);
        wait_done(0);

        // Card never acks: timeout after TMO cycles in ISSUE.
        card_mute = 1'b1;
        exp_q.push_back('{0, 32'h55, 1'b1, 1'b1, 0, TMO});
        req_lba[31:0] = 32'h55;
        req_rd[0] = 1'b1;
        wait_done(0);
        card_mute = 1'b0;

        // Reset during XFER with ack still high.
        exp_q.push_back('{0, 32'h77, 1'b0, 1'b0, 16, -1});
        req_lba[31:0] = 32'h77;
        req_buff_din[7:0] = 8'h3C;
        req_wr[0] = 1'b1;
        n = 0;
        while (req_ack[0] !== 1'b1 && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("xfer_reached", 32'(req_ack[0]), 32'd1);
        repeat (3) @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        chk("rst_xfer_grant", 32'(grant), 32'd0);
        chk("rst_xfer_cmd", 32'({sd_rd, sd_wr}), 32'd0);
        bad = 1'b0;
        n = 0;
        while (sd_ack && n < 200) begin
            if (grant != '0 || sd_rd || sd_wr) bad = 1'b1;
            @(negedge clk_sys);
            n++;
        end
        chk("stale_ack_block", 32'(bad), 32'd0);
        wait_done(0);

        repeat (5) @(negedge clk_sys);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
